// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// flush, and NOP insertion on the instruction field whenever the head is empty.
module wb_pipe_reg #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                RADDR_W  = 5,
    parameter int                RDATA_W  = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
    parameter bit                SKID     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [INST_W-1:0]  inst_i,
    input  logic [ADDR_W-1:0]  instaddr_i,
    input  logic               regs_wen_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic [RDATA_W-1:0] rd_data_i,
    input  logic               flush,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [INST_W-1:0]  inst_o,
    output logic [ADDR_W-1:0]  instaddr_o,
    output logic               regs_wen_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic [RDATA_W-1:0] rd_data_o,
    output logic [1:0]         occ_o
);

    typedef struct packed {
        logic [INST_W-1:0]  inst;
        logic [ADDR_W-1:0]  addr;
        logic               wen;
        logic [RADDR_W-1:0] rd_addr;
        logic [RDATA_W-1:0] rd_data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    entry_t     in_entry;
    entry_t     head;
    logic       head_valid;
    logic       ready;
    logic [1:0] occ;
    logic       take_in;
    logic       take_out;

    assign in_entry = {inst_i, instaddr_i, regs_wen_i, rd_addr_i, rd_data_i};
    assign take_in  = valid_i & ready;
    assign take_out = head_valid & ready_i;

    generate
        if (SKID) begin : g_skid
            state_t state;
            entry_t skid;
            logic   ready_q;

            // ready is registered, so a second entry may arrive while the head stalls; it waits in skid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                    head    <= '0;
                    skid    <= '0;
                end else if (flush) begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (take_in) begin
                                head  <= in_entry;
                                state <= ONE;
                            end
                        end
                        ONE: begin
                            if (take_in && take_out) begin
                                head <= in_entry;
                            end else if (take_in) begin
                                skid    <= in_entry;
                                state   <= TWO;
                                ready_q <= 1'b0;
                            end else if (take_out) begin
                                state <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (take_out) begin
                                head    <= skid;
                                state   <= ONE;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign ready      = ready_q;
            assign head_valid = (state != EMPTY);
            assign occ        = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
        end else begin : g_single
            logic valid_q;

            // Single entry: ready looks through to downstream so a consuming cycle can refill the head.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    head    <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (take_in) begin
                    head    <= in_entry;
                    valid_q <= 1'b1;
                end else if (take_out) begin
                    valid_q <= 1'b0;
                end
            end

            assign ready      = ~valid_q | ready_i;
            assign head_valid = valid_q;
            assign occ        = {1'b0, valid_q};
        end
    endgenerate

    // Only valid, inst and wen are masked; the data fields keep showing the last head.
    assign ready_o    = ready;
    assign valid_o    = head_valid;
    assign inst_o     = head_valid ? head.inst : NOP_INST;
    assign regs_wen_o = head.wen & head_valid;
    assign instaddr_o = head.addr;
    assign rd_addr_o  = head.rd_addr;
    assign rd_data_o  = head.rd_data;
    assign occ_o      = occ;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Drives a skid (SKID=1) and a single-entry (SKID=0) instance side by side and
// compares both against a queue-based scoreboard every cycle.
module tb_wb_pipe_reg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        wen;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } entry_t;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] inst_i;
    logic [31:0] instaddr_i;
    logic        regs_wen_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic [1:0]  valid_i_v;
    logic [1:0]  ready_i_v;
    logic [1:0]  ready_o_v;
    logic [1:0]  valid_o_v;
    logic [1:0]  regs_wen_o_v;
    logic [31:0] inst_o_v     [2];
    logic [31:0] instaddr_o_v [2];
    logic [4:0]  rd_addr_o_v  [2];
    logic [31:0] rd_data_o_v  [2];
    logic [1:0]  occ_o_v      [2];

    entry_t q0[$];
    entry_t q1[$];
    int     check_count = 0;
    int     pass_count  = 0;

    wb_pipe_reg #(.SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i_v[1]), .ready_o(ready_o_v[1]),
        .inst_i(inst_i), .instaddr_i(instaddr_i), .regs_wen_i(regs_wen_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .flush(flush),
        .valid_o(valid_o_v[1]), .ready_i(ready_i_v[1]), .inst_o(inst_o_v[1]),
        .instaddr_o(instaddr_o_v[1]), .regs_wen_o(regs_wen_o_v[1]),
        .rd_addr_o(rd_addr_o_v[1]), .rd_data_o(rd_data_o_v[1]), .occ_o(occ_o_v[1])
    );

    wb_pipe_reg #(.SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i_v[0]), .ready_o(ready_o_v[0]),
        .inst_i(inst_i), .instaddr_i(instaddr_i), .regs_wen_i(regs_wen_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .flush(flush),
        .valid_o(valid_o_v[0]), .ready_i(ready_i_v[0]), .inst_o(inst_o_v[0]),
        .instaddr_o(instaddr_o_v[0]), .regs_wen_o(regs_wen_o_v[0]),
        .rd_addr_o(rd_addr_o_v[0]), .rd_data_o(rd_data_o_v[0]), .occ_o(occ_o_v[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic entry_t mk(input int n);
        entry_t e;
        e.inst    = 32'h00000093 | (32'(n) << 20);
        e.addr    = 32'h00000200 + 32'(4 * n);
        e.wen     = (n % 3) != 0;
        e.rd_addr = 5'(n);
        e.rd_data = 32'(n * 1000 + 7);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare one instance against its scoreboard, then advance the model for the coming edge.
    task automatic evalDut(input int d);
        entry_t h;
        int     sz;
        logic   exp_ready;
        logic   exp_valid;
        sz        = (d == 1) ? q1.size() : q0.size();
        exp_valid = (sz > 0);
        h         = '0;
        if (exp_valid) h = (d == 1) ? q1[0] : q0[0];
        exp_ready = (d == 1) ? (sz < 2) : (sz == 0 || ready_i_v[0]);

        checkOutput($sformatf("valid_o[%0d]", d), 64'(valid_o_v[d]), 64'(exp_valid));
        checkOutput($sformatf("ready_o[%0d]", d), 64'(ready_o_v[d]), 64'(exp_ready));
        checkOutput($sformatf("occ_o[%0d]", d), 64'(occ_o_v[d]), 64'(sz));
        checkOutput($sformatf("inst_o[%0d]", d), 64'(inst_o_v[d]), 64'(exp_valid ? h.inst : NOP));
        checkOutput($sformatf("regs_wen_o[%0d]", d), 64'(regs_wen_o_v[d]), 64'(exp_valid & h.wen));
        if (exp_valid) begin
            checkOutput($sformatf("instaddr_o[%0d]", d), 64'(instaddr_o_v[d]), 64'(h.addr));
            checkOutput($sformatf("rd_addr_o[%0d]", d), 64'(rd_addr_o_v[d]), 64'(h.rd_addr));
            checkOutput($sformatf("rd_data_o[%0d]", d), 64'(rd_data_o_v[d]), 64'(h.rd_data));
        end

        if (rst || flush) begin
            if (d == 1) q1.delete(); else q0.delete();
        end else begin
            if (exp_valid && ready_i_v[d]) begin
                if (d == 1) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            if (valid_i_v[d] && exp_ready) begin
                if (d == 1) q1.push_back({inst_i, instaddr_i, regs_wen_i, rd_addr_i, rd_data_i});
                else        q0.push_back({inst_i, instaddr_i, regs_wen_i, rd_addr_i, rd_data_i});
            end
        end
    endtask

    task automatic applyStimulus(input logic v1, input logic v0, input logic r1, input logic r0,
                                 input entry_t e, input logic fl, input logic rs);
        valid_i_v  = {v1, v0};
        ready_i_v  = {r1, r0};
        {inst_i, instaddr_i, regs_wen_i, rd_addr_i, rd_data_i} = e;
        flush      = fl;
        rst        = rs;
        @(negedge clk);
        evalDut(1);
        evalDut(0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetFields();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst instaddr_o[%0d]", d), 64'(instaddr_o_v[d]), 64'd0);
            checkOutput($sformatf("rst rd_addr_o[%0d]", d), 64'(rd_addr_o_v[d]), 64'd0);
            checkOutput($sformatf("rst rd_data_o[%0d]", d), 64'(rd_data_o_v[d]), 64'd0);
        end
    endtask

    initial begin
        entry_t a;
        entry_t b;
        entry_t idle;
        a    = '{inst: 32'h00A00093, addr: 32'h100, wen: 1'b1, rd_addr: 5'd1, rd_data: 32'd10};
        b    = '{inst: 32'h01400113, addr: 32'h104, wen: 1'b1, rd_addr: 5'd2, rd_data: 32'd20};
        idle = mk(99);

        // Reset hold, then release with no traffic
        rst = 1'b1; flush = 1'b0; valid_i_v = 2'b00; ready_i_v = 2'b11;
        {inst_i, instaddr_i, regs_wen_i, rd_addr_i, rd_data_i} = idle;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetFields();
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        // Back-to-back stream with ready_i high on both instances
        applyStimulus(1, 1, 1, 1, a, 0, 0);
        applyStimulus(1, 1, 1, 1, b, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        // Skid fill: A, B accepted, C held upstream, then drained in order
        applyStimulus(1, 0, 0, 1, mk(1), 0, 0);
        applyStimulus(1, 0, 0, 1, mk(2), 0, 0);
        applyStimulus(1, 0, 0, 1, mk(3), 0, 0);
        applyStimulus(1, 0, 0, 1, mk(3), 0, 0);
        applyStimulus(1, 0, 1, 1, mk(3), 0, 0);
        applyStimulus(1, 0, 1, 1, mk(3), 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        // Fill, then flush with an input offered in the same cycle
        applyStimulus(1, 1, 0, 0, mk(4), 0, 0);
        applyStimulus(1, 1, 0, 0, mk(5), 0, 0);
        applyStimulus(1, 1, 0, 0, mk(6), 1, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        // Reset asserted mid-stream while full, then traffic resumes
        applyStimulus(1, 1, 0, 0, mk(7), 0, 0);
        applyStimulus(1, 1, 0, 0, mk(8), 0, 0);
        applyStimulus(1, 1, 0, 0, mk(9), 0, 1);
        checkResetFields();
        applyStimulus(1, 1, 1, 1, mk(10), 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        // Single-entry: stalled head drops ready_o, then same-cycle replace
        applyStimulus(0, 1, 1, 0, mk(11), 0, 0);
        applyStimulus(0, 1, 1, 0, mk(12), 0, 0);
        applyStimulus(0, 1, 1, 1, mk(12), 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        // Random handshake traffic with occasional flush
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          mk(100 + i), 1'($urandom_range(0, 9) == 0), 0);
        end
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);
        applyStimulus(0, 0, 1, 1, idle, 0, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register, successor to the plain load-enable write-back register. Carries the inst, instaddr, regs_wen, rd_addr and rd_data fields from the MEM stage to the register file. Uses a valid/ready handshake on both sides, an optional 2-entry skid buffer, a pipeline flush input, and bubble (NOP) insertion. Sits between mem and regs; also exports its occupancy to hazard logic.

Parameters:
INST_W, 32, instruction field width
ADDR_W, 32, instruction address width
RADDR_W, 5, register address width
RDATA_W, 32, write-back data width
NOP_INST, 32'h00000013, instruction value presented when no valid entry (addi x0,x0,0)
SKID, 1, 1 = 2-entry skid buffer (registered ready_o); 0 = single entry (combinational ready_o)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
valid_i  in  1  MEM stage presents a valid entry
ready_o  out  1  block can accept an entry this cycle
inst_i  in  INST_W  instruction
instaddr_i  in  ADDR_W  instruction address
regs_wen_i  in  1  register write enable
rd_addr_i  in  RADDR_W  destination register
rd_data_i  in  RDATA_W  write-back data
flush  in  1  discard all held entries
valid_o  out  1  head entry valid
ready_i  in  1  downstream consumes head this cycle
inst_o  out  INST_W  head instruction, NOP_INST when invalid
instaddr_o  out  ADDR_W  head address
regs_wen_o  out  1  regs_wen of head AND valid_o
rd_addr_o  out  RADDR_W  head destination
rd_data_o  out  RDATA_W  head data
occ_o  out  2  held entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst=1 at a clock edge): all entries invalid; valid_o=0, ready_o=1, inst_o=NOP_INST, instaddr_o=0, regs_wen_o=0, rd_addr_o=0, rd_data_o=0, occ_o=0. Reset overrides flush and all handshakes, including a reset asserted mid-transfer.
- Transfer in: valid_i & ready_o at the edge. Transfer out: valid_o & ready_i at the edge.
- Latency: an accepted entry appears on the outputs in the next cycle; a stream with ready_i=1 flows at 1 entry/cycle.
- SKID=1 states (head H, skid S):
  - EMPTY: occ=0. ready_o=1. On in, go to ONE with H=in.
  - ONE: occ=1.
    - in & out: H=in, stay in ONE.
    - in & !out: S=in, go to TWO.
    - out & !in: go to EMPTY.
  - TWO: ready_o=0. On out: H=S, go to ONE. valid_i is ignored in TWO.
  - ready_o is a register output: ready_o = !(state==TWO).
- SKID=0: single head entry. ready_o = !valid_o | ready_i (combinational). An in and out in the same cycle replaces the head.
- flush=1 at an edge:
  - all entries become invalid, state goes to EMPTY, and an input offered that cycle is dropped.
  - Next cycle: valid_o=0, inst_o=NOP_INST, regs_wen_o=0.
  - Data fields hold their last value; only valid, inst and wen are forced.
- regs_wen_o is never 1 while valid_o=0. This guarantees no spurious register-file write.
- Entry order is strict FIFO. No entry is duplicated or lost except by flush or reset.
- Ports with no ready_i back-pressure (ready_i tied 1) behave as the legacy register when lden=valid_i. Bubble cycles give inst_o=NOP_INST.

Test Plan:
1. Reset hold then release, no traffic -> valid_o=0, inst_o=32'h00000013, regs_wen_o=0, ready_o=1, occ_o=0.
2. ready_i=1, send inst 0x00A00093/addr 0x100/rd 1/data 10, then addr 0x104 back-to-back -> each appears 1 cycle later, valid_o=1 for 2 consecutive cycles, order preserved.
3. SKID=1: send A, B, C back-to-back with ready_i=0 -> A is head, B in skid, occ_o=2, ready_o=0 while C is held upstream. Raise ready_i -> outputs A, B, C on consecutive cycles with none lost.
4. occ_o=2, then flush=1 with valid_i=1 in the same cycle -> next cycle valid_o=0, regs_wen_o=0, inst_o=NOP, occ_o=0; the flushed input is absent from later output.
5. Assert rst mid-stream while occ_o=2 -> next cycle all outputs are at reset values; the first post-reset entry flows normally.
6. SKID=0: ready_i=0 with head valid -> ready_o=0 the same cycle. Raise ready_i=1 with valid_i=1 -> head is replaced in that cycle and occ_o stays 1.
